tile_update_master: RTL and testbench
=====================================

Name: tile_update_master

Overview:
- Bus initiator that drives tile-map updates into the tile display peripheral over its 16-bit Avalon-MM write port.
- Software or game logic hands it (tile index, tile id) pairs on a valid/ready stream, or requests a whole-screen fill.
- It buffers the pairs, converts each into index/data register writes, honours waitrequest, and skips redundant index writes using the peripheral's auto-increment.
- It sits between the HPS-side control logic and the display's chipselect/write/address/writedata slave port.

Parameters:
FIFO_DEPTH, 16, update FIFO entries (power of 2, >=2)
NUM_TILES, 4800, tile-map entries (80x60 tiles of 8x8 px); valid index range 0..NUM_TILES-1

Ports:
clk  in  1  system clock (50 MHz)
reset  in  1  synchronous, active-low reset
upd_valid  in  1  update request valid
upd_ready  out  1  update accepted when upd_valid && upd_ready
upd_index  in  13  target tile index
upd_tile  in  6  tile id to write
fill_req  in  1  single-cycle pulse: fill entire map with fill_tile
fill_tile  in  6  fill tile id, sampled on the fill_req cycle
fill_busy  out  1  fill pending or in progress
busy  out  1  FIFO non-empty, FSM not IDLE, or fill pending
err_range  out  1  one-cycle pulse: accepted update had upd_index >= NUM_TILES
m_address  out  3  peripheral register address
m_writedata  out  16  peripheral write data
m_write  out  1  write strobe
m_chipselect  out  1  equals m_write
m_waitrequest  in  1  peripheral stall

Behaviour:
- Peripheral register map:
  - addr 0 = index latch, writedata {3'b0, index[12:0]}.
  - addr 1 = tile commit, writedata {10'b0, tile[5:0]}. Writes tiles[latch], then latch = latch+1, wrapping NUM_TILES-1 -> 0.
- A bus write completes in a cycle with m_write=1 and m_waitrequest=0.
- While m_waitrequest=1, m_address, m_writedata and m_write are held stable.
- Reset (reset==0 at a clk edge):
  - m_write, m_chipselect, m_address, m_writedata, err_range, fill_busy and busy = 0.
  - upd_ready = 0 during reset.
  - FIFO empty; shadow pointer ptr = 0, ptr_valid = 0; FSM in IDLE.
  - Reset mid-transaction aborts the write: m_write is 0 in the first cycle after the reset edge, and queued entries are discarded.
- Input acceptance:
  - upd_ready = !fifo_full && !fill_busy.
  - Out-of-range index: the update is accepted but not enqueued; err_range = 1 on the following cycle.
- Shadow pointer tracks the peripheral latch:
  - After an addr 0 write completes: ptr = index, ptr_valid = 1.
  - After an addr 1 write completes: ptr = (ptr+1) mod NUM_TILES.
- FSM states: IDLE, WR_INDEX, WR_DATA, FILL_INDEX, FILL_DATA.
  - IDLE, fill pending: go to FILL_INDEX. Fill has priority over FIFO entries; queued entries are preserved and drained after the fill.
  - IDLE, FIFO non-empty: pop the head. If ptr_valid && head.index == ptr, go to WR_DATA; otherwise go to WR_INDEX.
  - WR_INDEX: m_write=1, addr 0. On completion go to WR_DATA.
  - WR_DATA: m_write=1, addr 1. On completion:
    - fill pending: go to FILL_INDEX;
    - FIFO non-empty: pop and go directly to WR_INDEX/WR_DATA (no idle bubble);
    - otherwise go to IDLE.
  - FILL_INDEX: write addr 0 with index 0, then go to FILL_DATA.
  - FILL_DATA: NUM_TILES consecutive addr 1 writes of fill_tile (13-bit counter), then return to IDLE with ptr = 0, ptr_valid = 1. fill_busy clears on the final completion.
- fill_req while fill_busy=1 is ignored.
- Latency: an update accepted in cycle N into an empty FIFO with FSM in IDLE has m_write=1 in cycle N+2. Steady state is 1 write per clock when m_waitrequest=0.
- FIFO full: upd_ready=0. A pop in cycle N raises upd_ready in N+1 (registered full flag).
- Push and pop in the same cycle are permitted when the FIFO is non-empty and not full; the count is unchanged.

Test Plan:
- Single update {35,23} after reset → writes (0,0x0023), then (1,0x0017); busy drops the cycle after the second completes.
- Updates {36,5}, {37,9} following {35,23} → only addr 1 writes 0x0005, 0x0009 back-to-back, no index writes.
- m_waitrequest held high 3 cycles during the index write of {3765,12} → address/data stable for 4 cycles; then (1,0x000C) follows.
- upd_index=4800 → err_range pulses once, no bus activity, ptr unchanged.
- fill_req with fill_tile=10 while 2 updates are queued → after the in-flight write: (0,0), then 4800× (1,0x000A), then the queued updates; update index 0 after the fill skips its index write.
- 17 pushes with m_waitrequest held high → upd_ready low after 16 accepted. Assert reset mid-stream → m_write=0 the next cycle, FIFO empty, next update issues an index write.

Source files
------------

// File: rtl/tile_update_master.sv
// Avalon-MM initiator that turns queued (tile index, tile id) updates and whole-map fills
// into index-latch / tile-commit writes for the tile display peripheral.
module tile_update_master #(
  parameter int FIFO_DEPTH = 16,
  parameter int NUM_TILES  = 4800
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        upd_valid,
  output logic        upd_ready,
  input  logic [12:0] upd_index,
  input  logic [5:0]  upd_tile,
  input  logic        fill_req,
  input  logic [5:0]  fill_tile,
  output logic        fill_busy,
  output logic        busy,
  output logic        err_range,
  output logic [2:0]  m_address,
  output logic [15:0] m_writedata,
  output logic        m_write,
  output logic        m_chipselect,
  input  logic        m_waitrequest
);

  localparam int          AW          = $clog2(FIFO_DEPTH);
  localparam logic [12:0] LAST_IDX    = 13'(NUM_TILES - 1);
  localparam logic [13:0] NUM_TILES_W = 14'(NUM_TILES);
  localparam logic [AW:0] DEPTH_W     = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, WR_INDEX, WR_DATA, FILL_INDEX, FILL_DATA} state_t;

  state_t      state_q, state_d;
  logic [18:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0] count_q, count_d;
  logic        full_q, full_d;
  logic [12:0] ptr_q, ptr_d;
  logic        ptr_valid_q, ptr_valid_d;
  logic [12:0] cur_index_q, cur_index_d;
  logic [5:0]  cur_tile_q, cur_tile_d;
  logic [5:0]  fill_tile_q, fill_tile_d;
  logic        fill_busy_q, fill_busy_d;
  logic [12:0] fill_cnt_q, fill_cnt_d;
  logic        err_range_q, err_range_d;

  logic        accept, in_range, push, pop, fifo_empty, done, fill_pending;
  logic [12:0] head_index;
  logic [5:0]  head_tile;

  assign fifo_empty   = (count_q == '0);
  assign upd_ready    = reset && !full_q && !fill_busy_q;
  assign accept       = upd_valid && upd_ready;
  assign in_range     = ({1'b0, upd_index} < NUM_TILES_W);
  assign push         = accept && in_range;
  assign m_write      = (state_q != IDLE);
  assign m_chipselect = m_write;
  assign done         = m_write && !m_waitrequest;
  assign fill_pending = fill_busy_q && (state_q != FILL_INDEX) && (state_q != FILL_DATA);
  assign {head_index, head_tile} = mem_q[rd_ptr_q];
  assign fill_busy    = fill_busy_q;
  assign err_range    = err_range_q;
  assign busy         = !fifo_empty || (state_q != IDLE) || fill_busy_q;

  always_comb begin
    m_address   = 3'd0;
    m_writedata = 16'd0;
    case (state_q)
      WR_INDEX:   begin m_address = 3'd0; m_writedata = {3'b0, cur_index_q}; end
      WR_DATA:    begin m_address = 3'd1; m_writedata = {10'b0, cur_tile_q}; end
      FILL_INDEX: begin m_address = 3'd0; m_writedata = 16'd0; end
      FILL_DATA:  begin m_address = 3'd1; m_writedata = {10'b0, fill_tile_q}; end
      default:    ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    ptr_valid_d = ptr_valid_q;
    cur_index_d = cur_index_q;
    cur_tile_d  = cur_tile_q;
    fill_tile_d = fill_tile_q;
    fill_busy_d = fill_busy_q;
    fill_cnt_d  = fill_cnt_q;
    err_range_d = accept && !in_range;
    pop         = 1'b0;

    // Shadow of the peripheral's index latch, updated as each write completes.
    if (done) begin
      case (state_q)
        WR_INDEX:   begin ptr_d = cur_index_q; ptr_valid_d = 1'b1; end
        FILL_INDEX: begin ptr_d = 13'd0;       ptr_valid_d = 1'b1; end
        default:    ptr_d = (ptr_q == LAST_IDX) ? 13'd0 : ptr_q + 13'd1;
      endcase
    end

    case (state_q)
      IDLE: begin
        if (fill_pending)     state_d = FILL_INDEX;
        else if (!fifo_empty) pop = 1'b1;
      end
      WR_INDEX: if (done) state_d = WR_DATA;
      WR_DATA: begin
        if (done) begin
          if (fill_pending)     state_d = FILL_INDEX;
          else if (!fifo_empty) pop = 1'b1;
          else                  state_d = IDLE;
        end
      end
      FILL_INDEX: begin
        if (done) begin
          state_d    = FILL_DATA;
          fill_cnt_d = 13'd0;
        end
      end
      FILL_DATA: begin
        if (done) begin
          if (fill_cnt_q == LAST_IDX) begin
            state_d     = IDLE;
            fill_busy_d = 1'b0;
          end else begin
            fill_cnt_d = fill_cnt_q + 13'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // The skip decision uses the latch value after this cycle's completion.
    if (pop) begin
      cur_index_d = head_index;
      cur_tile_d  = head_tile;
      state_d     = (ptr_valid_d && head_index == ptr_d) ? WR_DATA : WR_INDEX;
    end

    if (fill_req && !fill_busy_q) begin
      fill_busy_d = 1'b1;
      fill_tile_d = fill_tile;
    end
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + (AW + 1)'(push) - (AW + 1)'(pop);
    full_d   = (count_d == DEPTH_W);
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {upd_index, upd_tile};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      ptr_q       <= 13'd0;
      ptr_valid_q <= 1'b0;
      cur_index_q <= 13'd0;
      cur_tile_q  <= 6'd0;
      fill_tile_q <= 6'd0;
      fill_busy_q <= 1'b0;
      fill_cnt_q  <= 13'd0;
      err_range_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      full_q      <= full_d;
      ptr_q       <= ptr_d;
      ptr_valid_q <= ptr_valid_d;
      cur_index_q <= cur_index_d;
      cur_tile_q  <= cur_tile_d;
      fill_tile_q <= fill_tile_d;
      fill_busy_q <= fill_busy_d;
      fill_cnt_q  <= fill_cnt_d;
      err_range_q <= err_range_d;
    end
  end

endmodule

// File: tb/tb_tile_update_master.sv
// Bench for tile_update_master: directed scenarios plus a randomized phase, with every
// completed bus write checked against a queue of writes predicted from the register-map rules.
module tb_tile_update_master;

  localparam int NT = 4800;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        upd_valid = 1'b0;
  logic        upd_ready;
  logic [12:0] upd_index = '0;
  logic [5:0]  upd_tile = '0;
  logic        fill_req = 1'b0;
  logic [5:0]  fill_tile = '0;
  logic        fill_busy, busy, err_range;
  logic [2:0]  m_address;
  logic [15:0] m_writedata;
  logic        m_write, m_chipselect;
  logic        m_waitrequest = 1'b0;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  logic [18:0] exp_q[$];
  int          done_cyc[$];
  int          m_ptr = 0;
  bit          m_ptr_valid = 1'b0;

  tile_update_master #(.FIFO_DEPTH(16), .NUM_TILES(NT)) dut (
    .clk(clk), .reset(reset),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_index(upd_index), .upd_tile(upd_tile),
    .fill_req(fill_req), .fill_tile(fill_tile), .fill_busy(fill_busy),
    .busy(busy), .err_range(err_range),
    .m_address(m_address), .m_writedata(m_writedata), .m_write(m_write),
    .m_chipselect(m_chipselect), .m_waitrequest(m_waitrequest)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: an update writes the index latch only when the latch does not already hold it.
  function automatic void emitUpdate(input int idx, input int tile);
    if (idx >= NT) return;
    if (!(m_ptr_valid && m_ptr == idx)) exp_q.push_back({3'd0, 16'(idx)});
    exp_q.push_back({3'd1, 16'(tile)});
    m_ptr = (idx + 1) % NT;
    m_ptr_valid = 1'b1;
  endfunction

  function automatic void emitFill(input int tile);
    exp_q.push_back({3'd0, 16'd0});
    for (int i = 0; i < NT; i++) exp_q.push_back({3'd1, 16'(tile)});
    m_ptr = 0;
    m_ptr_valid = 1'b1;
  endfunction

  logic [2:0]  prev_addr;
  logic [15:0] prev_data;
  bit          prev_stall = 1'b0;

  // Bus monitor: reset here is the value the next rising edge will sample.
  always @(negedge clk) begin
    logic [18:0] e;
    checkOutput("chipselect", 32'(m_chipselect), 32'(m_write));
    if (prev_stall) begin
      checkOutput("hold_write", 32'(m_write), 32'd1);
      checkOutput("hold_addr", 32'(m_address), 32'(prev_addr));
      checkOutput("hold_data", 32'(m_writedata), 32'(prev_data));
    end
    prev_stall = reset && m_write && m_waitrequest;
    prev_addr  = m_address;
    prev_data  = m_writedata;
    if (reset && m_write && !m_waitrequest) begin
      done_cyc.push_back(cyc);
      vectors++;
      assert (exp_q.size() != 0) else begin
        miscompares++;
        $error("[TB] FAIL unexpected_write observed=%0h/%0h expected=none", m_address, m_writedata);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checkOutput("wr_addr", 32'(m_address), 32'(e[18:16]));
        checkOutput("wr_data", 32'(m_writedata), 32'(e[15:0]));
      end
    end
  end

  task automatic applyStimulus(input int idx, input int tile, input int budget,
                               input bit do_model, output bit accepted);
    int n = 0;
    upd_index = 13'(idx);
    upd_tile  = 6'(tile);
    upd_valid = 1'b1;
    while (!upd_ready && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    if (!upd_ready) begin
      accepted  = 1'b0;
      upd_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    accepted  = 1'b1;
    upd_valid = 1'b0;
    if (do_model) emitUpdate(idx, tile);
    checkOutput("err_range", 32'(err_range), 32'(idx >= NT));
  endtask

  task automatic waitWrite(input string tag);
    int n = 0;
    while (!m_write && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput(tag, 32'(m_write), 32'd1);
  endtask

  task automatic waitDrain(input string tag, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    bit acc;
    int idx, tile, last, r;
    bit acc_now;

    $display("[TB] start");
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_m_write", 32'(m_write), 32'd0);
    checkOutput("rst_upd_ready", 32'(upd_ready), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_fill_busy", 32'(fill_busy), 32'd0);
    checkOutput("rst_err", 32'(err_range), 32'd0);
    checkOutput("rst_addr", 32'(m_address), 32'd0);
    checkOutput("rst_data", 32'(m_writedata), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    checkOutput("post_rst_ready", 32'(upd_ready), 32'd1);

    // Single update: index write two cycles after acceptance, then the tile write.
    applyStimulus(35, 23, 5, 1'b1, acc);
    checkOutput("t1_n1_write", 32'(m_write), 32'd0);
    @(posedge clk); #1;
    checkOutput("t1_n2_write", 32'(m_write), 32'd1);
    checkOutput("t1_n2_addr", 32'(m_address), 32'd0);
    checkOutput("t1_n2_data", 32'(m_writedata), 32'h0023);
    @(posedge clk); #1;
    checkOutput("t1_n3_addr", 32'(m_address), 32'd1);
    checkOutput("t1_n3_data", 32'(m_writedata), 32'h0017);
    checkOutput("t1_n3_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    checkOutput("t1_n4_busy", 32'(busy), 32'd0);
    waitDrain("t1", 20);

    // Consecutive indices: tile writes only, back to back.
    done_cyc.delete();
    applyStimulus(36, 5, 5, 1'b1, acc);
    applyStimulus(37, 9, 5, 1'b1, acc);
    waitDrain("t2", 20);
    checkOutput("t2_writes", 32'(done_cyc.size()), 32'd2);
    if (done_cyc.size() == 2) checkOutput("t2_gap", 32'(done_cyc[1] - done_cyc[0]), 32'd1);

    // Out-of-range index: one err pulse, nothing on the bus, latch shadow untouched.
    applyStimulus(4800, 1, 5, 1'b1, acc);
    @(posedge clk); #1;
    checkOutput("t3_err_pulse", 32'(err_range), 32'd0);
    checkOutput("t3_busy", 32'(busy), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    applyStimulus(38, 2, 5, 1'b1, acc);
    waitDrain("t3", 20);

    // Stalled index write holds the bus stable.
    m_waitrequest = 1'b1;
    applyStimulus(3765, 12, 5, 1'b1, acc);
    waitWrite("t4_write");
    repeat (3) @(posedge clk);
    #1;
    checkOutput("t4_addr", 32'(m_address), 32'd0);
    checkOutput("t4_data", 32'(m_writedata), 32'd3765);
    m_waitrequest = 1'b0;
    waitDrain("t4", 20);

    // Fill requested with one update in flight and two queued.
    m_waitrequest = 1'b1;
    applyStimulus(100, 3, 5, 1'b0, acc);
    waitWrite("t5_write");
    applyStimulus(0, 7, 5, 1'b0, acc);
    applyStimulus(1, 8, 5, 1'b0, acc);
    fill_tile = 6'd10;
    fill_req  = 1'b1;
    @(posedge clk); #1;
    fill_req = 1'b0;
    checkOutput("t5_fill_busy", 32'(fill_busy), 32'd1);
    checkOutput("t5_ready", 32'(upd_ready), 32'd0);
    fill_tile = 6'd20;
    fill_req  = 1'b1;
    @(posedge clk); #1;
    fill_req = 1'b0;
    emitUpdate(100, 3);
    emitFill(10);
    emitUpdate(0, 7);
    emitUpdate(1, 8);
    m_waitrequest = 1'b0;
    waitDrain("t5", 6000);
    checkOutput("t5_fill_done", 32'(fill_busy), 32'd0);

    // Randomized updates against a randomly stalling peripheral.
    last = 40;
    idx = 0;
    for (int c = 0; c < 400; c++) begin
      m_waitrequest = ($urandom_range(0, 9) < 3);
      if (!upd_valid && $urandom_range(0, 3) != 0) begin
        r = $urandom_range(0, 99);
        if (r < 45)      idx = (last + 1) % NT;
        else if (r < 55) idx = NT - 1;
        else if (r < 90) idx = $urandom_range(0, NT - 1);
        else             idx = NT + $urandom_range(0, 3000);
        if (idx < NT) last = idx;
        tile = $urandom_range(0, 63);
        upd_index = 13'(idx);
        upd_tile  = 6'(tile);
        upd_valid = 1'b1;
      end
      @(negedge clk);
      acc_now = upd_valid && upd_ready;
      @(posedge clk); #1;
      if (acc_now) begin
        emitUpdate(idx, tile);
        upd_valid = 1'b0;
      end
      checkOutput("rand_err_range", 32'(err_range), 32'(acc_now && idx >= NT));
    end
    upd_valid = 1'b0;
    m_waitrequest = 1'b0;
    waitDrain("rand", 200);

    // Fill the FIFO behind a stalled write, then reset mid-stream.
    m_waitrequest = 1'b1;
    applyStimulus(200, 1, 5, 1'b1, acc);
    waitWrite("t6_write");
    for (int i = 0; i < 16; i++) begin
      applyStimulus(300 + i, i, 2, 1'b1, acc);
      checkOutput("t6_accept", 32'(acc), 32'd1);
    end
    checkOutput("t6_full_ready", 32'(upd_ready), 32'd0);
    applyStimulus(400, 1, 3, 1'b1, acc);
    checkOutput("t6_17th", 32'(acc), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    checkOutput("t6_rst_write", 32'(m_write), 32'd0);
    checkOutput("t6_rst_busy", 32'(busy), 32'd0);
    checkOutput("t6_rst_ready", 32'(upd_ready), 32'd0);
    reset = 1'b1;
    m_waitrequest = 1'b0;
    exp_q.delete();
    m_ptr_valid = 1'b0;
    @(posedge clk); #1;
    checkOutput("t6_ready_back", 32'(upd_ready), 32'd1);
    applyStimulus(300, 5, 5, 1'b1, acc);
    @(posedge clk); #1;
    checkOutput("t6_index_addr", 32'(m_address), 32'd0);
    checkOutput("t6_index_data", 32'(m_writedata), 32'd300);
    waitDrain("t6", 20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
